// File: rtl/programmable_clock_divider.sv
// Programmable integer clock divider.
// Divides reference_clk by active_ratio (N >= 2); otherwise, or when the
// divider is disabled, reference_clk is passed straight through.
// A new division_ratio takes effect only at a period boundary (or at once
// while bypassed), so a running period is never truncated or stretched.
// Optional build macro DIV_DUTY50_EN: for odd ratios the falling edge of the
// divided clock is delayed by half a reference period through a
// negedge-reference_clk flop, giving a 50% duty cycle.
module programmable_clock_divider #(
    parameter int RATIO_WIDTH = 8
) (
    input  logic                   reference_clk,
    input  logic                   reset,
    input  logic                   clk_divider_enable,
    input  logic [RATIO_WIDTH-1:0] division_ratio,
    output logic                   output_clk,
    output logic                   div_edge,
    output logic [RATIO_WIDTH-1:0] active_ratio,
    output logic                   ratio_update_done
);

    logic [RATIO_WIDTH-1:0] period_count;
    logic [RATIO_WIDTH-1:0] next_count;
    logic [RATIO_WIDTH-1:0] last_count;
    logic [RATIO_WIDTH-1:0] half_point;
    logic                   divided_clk;
    logic                   running;
    logic                   bypass;
    logic                   at_wrap;
    logic                   load_ratio;
    logic                   shaped_clk;

    // Ratios below 2 cannot be divided, so they fall back to pass-through.
    assign bypass     = !clk_divider_enable || (active_ratio < RATIO_WIDTH'(2));
    assign last_count = active_ratio - RATIO_WIDTH'(1);
    assign half_point = active_ratio >> 1;
    assign next_count = period_count + RATIO_WIDTH'(1);
    assign at_wrap    = running && (period_count == last_count);
    assign load_ratio = bypass || at_wrap;

    // Ratio register: reloads only at a period boundary or while bypassed,
    // flagging a change of value for one cycle.
    always_ff @(posedge reference_clk or negedge reset) begin
        if (!reset) begin
            active_ratio      <= '0;
            ratio_update_done <= 1'b0;
        end else begin
            ratio_update_done <= load_ratio && (division_ratio != active_ratio);
            if (load_ratio) begin
                active_ratio <= division_ratio;
            end
        end
    end

    // Period counter and divided clock. The first posedge after leaving
    // bypass starts a fresh period with the output high; the output drops
    // when the counter reaches half the ratio and rises again on wrap.
    always_ff @(posedge reference_clk or negedge reset) begin
        if (!reset) begin
            period_count <= '0;
            divided_clk  <= 1'b0;
            running      <= 1'b0;
        end else if (bypass) begin
            period_count <= '0;
            divided_clk  <= 1'b0;
            running      <= 1'b0;
        end else if (!running) begin
            period_count <= '0;
            divided_clk  <= 1'b1;
            running      <= 1'b1;
        end else if (at_wrap) begin
            period_count <= '0;
            divided_clk  <= 1'b1;
        end else begin
            period_count <= next_count;
            if (next_count == half_point) begin
                divided_clk <= 1'b0;
            end
        end
    end

    // Edge marker: high for the whole reference cycle that opens a period.
    assign div_edge = running && !bypass && (period_count == '0);

`ifdef DIV_DUTY50_EN
    logic divided_late;

    // Half-cycle delayed copy used to stretch the high phase of odd ratios.
    always_ff @(negedge reference_clk or negedge reset) begin
        if (!reset) begin
            divided_late <= 1'b0;
        end else begin
            divided_late <= divided_clk;
        end
    end

    assign shaped_clk = active_ratio[0] ? (divided_clk | divided_late) : divided_clk;
`else
    assign shaped_clk = divided_clk;
`endif

    // Bypass switches to the reference clock combinationally.
    assign output_clk = bypass ? reference_clk : shaped_clk;

endmodule
